// File: rtl/fp24_pixel_packer_pkg.sv
// Shared FP24 definitions plus the RGB565 pixel format and the packer's FSM types.
package fp24_pixel_packer_pkg;

  localparam int FP24_BIAS   = 63;
  localparam int FP24_EXP_W  = 7;
  localparam int FP24_MANT_W = 16;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 180;

  typedef struct packed {
    logic                   sign;
    logic [FP24_EXP_W-1:0]  exp;
    logic [FP24_MANT_W-1:0] mant;
  } fp24_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel565_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_OUT
  } state_t;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } chan_t;

  // Keeps the most significant bits of each unorm8 channel.
  function automatic pixel565_t pack565(input logic [7:0] r8,
                                        input logic [7:0] g8,
                                        input logic [7:0] b8);
    pixel565_t p;
    p.r = r8[7:3];
    p.g = g8[7:2];
    p.b = b8[7:3];
    return p;
  endfunction

endpackage

// File: rtl/fp24_pixel_packer_conv.sv
// Combinational FP24 -> unorm8 converter: floor(v*256), negatives/zero to 0, v >= 1 saturating to 255.
module fp24_to_unorm8
  import fp24_pixel_packer_pkg::*;
(
  input  fp24_t      value,
  output logic [7:0] unorm
);

  localparam logic [FP24_EXP_W-1:0] EXP_ONE = FP24_EXP_W'(FP24_BIAS);
  localparam logic [FP24_EXP_W-1:0] EXP_MIN = FP24_EXP_W'(FP24_BIAS - 8);

  logic [2:0] k;
  logic [4:0] shift;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    unorm = '0;
    k     = 3'(value.exp - EXP_MIN);
    shift = 5'd16 - {2'b00, k};
    if (value.sign || value.exp == '0) begin
      unorm = '0;
    end else if (value.exp >= EXP_ONE) begin
      unorm = 8'hFF;
    end else if (value.exp < EXP_MIN) begin
      unorm = '0;
    end else begin
      // Hidden one at bit 16; k in 0..7 keeps the result within 8 bits.
      unorm = 8'({1'b1, value.mant} >> shift);
    end
  end

endmodule

// File: rtl/fp24_pixel_packer.sv
// Converts one FP24 RGB triple per pixel through a time-shared converter, packs to RGB565
// and emits it with a wrapping linear framebuffer address.
module fp24_pixel_packer
  import fp24_pixel_packer_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  fp24_t             in_r,
  input  fp24_t             in_g,
  input  fp24_t             in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_pixel,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  state_t state_q, state_d;
  chan_t  ch_q, ch_d;

  fp24_t       r_q, g_q, b_q;
  fp24_t       conv_in;
  logic [7:0]  conv_out;
  logic [7:0]  r8_q, g8_q, b8_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  pixel565_t   pixel_q;
  logic [ADDR_W-1:0] addr_q;
  logic        last_q;

  logic accept;
  logic emit;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  assign out_pixel = pixel_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= CH_R;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CONV;
          ch_d    = CH_R;
        end
      end
      ST_CONV: begin
        unique case (ch_q)
          CH_R:    ch_d = CH_G;
          CH_G:    ch_d = CH_B;
          default: begin
            ch_d    = CH_R;
            state_d = ST_OUT;
          end
        endcase
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case (ch_q)
      CH_R:    conv_in = r_q;
      CH_G:    conv_in = g_q;
      default: conv_in = b_q;
    endcase
  end

  fp24_to_unorm8 u_conv (
    .value (conv_in),
    .unorm (conv_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      r8_q       <= '0;
      g8_q       <= '0;
      b8_q       <= '0;
      addr_cnt_q <= '0;
      pixel_q    <= '0;
      addr_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      if (accept) begin
        r_q <= in_r;
        g_q <= in_g;
        b_q <= in_b;
      end

      if (state_q == ST_CONV) begin
        unique case (ch_q)
          CH_R: r8_q <= conv_out;
          CH_G: g8_q <= conv_out;
          default: begin
            // Blue is packed straight from the converter so the pixel is ready as OUT begins.
            b8_q    <= conv_out;
            pixel_q <= pack565(r8_q, g8_q, conv_out);
            addr_q  <= addr_cnt_q;
            last_q  <= (addr_cnt_q == LAST_ADDR);
          end
        endcase
      end

      if (emit) begin
        addr_cnt_q <= (addr_cnt_q == LAST_ADDR) ? '0 : addr_cnt_q + 1'b1;
        last_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp24_pixel_packer.sv
// Directed bench for fp24_pixel_packer; the frame is shrunk to 8x4 so the address wrap fits a short run.
module tb_fp24_pixel_packer;
  import fp24_pixel_packer_pkg::*;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int FRAME = H * V;
  localparam int AW    = $clog2(FRAME);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  fp24_t         in_r, in_g, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_pixel;
  logic [AW-1:0] out_addr;
  logic          out_last;

  int vectors     = 0;
  int miscompares = 0;

  fp24_pixel_packer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic fp24_t fp(input logic s, input logic [6:0] e, input logic [15:0] m);
    fp24_t f;
    f.sign = s;
    f.exp  = e;
    f.mant = m;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one triple for a single accepting cycle and waits (bounded) for out_valid.
  task automatic send(input fp24_t r, input fp24_t g, input fp24_t b, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    in_r     = r;
    in_g     = g;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Sends a triple with out_ready high and checks latency, the packed word, channels and address.
  task automatic pixel_case(input string tag, input fp24_t r, input fp24_t g, input fp24_t b,
                            input logic [15:0] px, input logic [7:0] r8, input logic [7:0] g8,
                            input logic [7:0] b8, input logic [AW-1:0] addr);
    int lat;
    out_ready = 1'b1;
    send(r, g, b, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_pixel"}, out_pixel, px);
    check({tag, "_r8"}, dut.r8_q, r8);
    check({tag, "_g8"}, dut.g8_q, g8);
    check({tag, "_b8"}, dut.b8_q, b8);
    check({tag, "_addr"}, out_addr, addr);
    check({tag, "_last"}, out_last, 1'b0);
    tick();
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_pixel_hold"}, out_pixel, px);
    check({tag, "_addr_hold"}, out_addr, addr);
  endtask

  initial begin
    int lat;
    int seen;
    int last_pulses;
    int last_cycle;
    int stray_last;
    int exp_addr;
    int stray_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_r      = '0;
    in_g      = '0;
    in_b      = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pixel", out_pixel, 16'h0000);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_last", out_last, 1'b0);

    // 1.0 / 0.5 / 0.75 -> 255/128/192.
    pixel_case("basic", fp(0, 7'd63, 16'h0000), fp(0, 7'd62, 16'h0000), fp(0, 7'd62, 16'h8000),
               16'hFC18, 8'd255, 8'd128, 8'd192, 0);
    // Negative, e=-9, and k=0 with full mantissa -> 0/0/1; blue's LSB is truncated by the pack.
    pixel_case("small", fp(1, 7'd63, 16'h0000), fp(0, 7'd54, 16'hFFFF), fp(0, 7'd55, 16'hFFFF),
               16'h0000, 8'd0, 8'd0, 8'd1, 1);
    // e=7 saturates, all-zero word is 0, 1.25*2^-3 -> 40.
    pixel_case("sat", fp(0, 7'd70, 16'h0000), fp(0, 7'd0, 16'h0000), fp(0, 7'd60, 16'h4000),
               16'hF805, 8'd255, 8'd0, 8'd40, 2);
    // Just below 1.0 peaks at 255, negative with large exponent is 0, max exponent saturates.
    pixel_case("edge", fp(0, 7'd62, 16'hFFFF), fp(1, 7'd63, 16'h1234), fp(0, 7'd127, 16'hFFFF),
               16'hF81F, 8'd255, 8'd0, 8'd255, 3);

    // Reset while a pixel is mid-conversion; the address counter had reached 4.
    in_r     = fp(0, 7'd63, 16'h0000);
    in_g     = fp(0, 7'd63, 16'h0000);
    in_b     = fp(0, 7'd63, 16'h0000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("conv_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_out_pixel", out_pixel, 16'h0000);
    check("midrst_r8", dut.r8_q, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stray_valid = 0;
    repeat (10) begin
      tick();
      if (out_valid) stray_valid++;
    end
    check("dropped_pixel_absent", stray_valid, 0);

    // Backpressure: output held for 10 cycles while the next triple waits upstream.
    out_ready = 1'b0;
    send(fp(0, 7'd62, 16'h0000), fp(0, 7'd61, 16'h0000), fp(0, 7'd0, 16'h0000), lat);
    check("bp_latency", lat, 4);
    check("bp_pixel", out_pixel, 16'h8200);
    check("bp_addr", out_addr, 0);
    in_r     = fp(0, 7'd63, 16'h0000);
    in_g     = fp(0, 7'd63, 16'h0000);
    in_b     = fp(0, 7'd63, 16'h0000);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_pixel", out_pixel, 16'h8200);
      check("bp_hold_addr", out_addr, 0);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_next_latency", lat, 4);
    check("bp_next_pixel", out_pixel, 16'hFFFF);
    check("bp_next_addr", out_addr, 1);
    tick();

    // Continuous stream across the frame wrap, starting from address 2.
    in_r        = fp(0, 7'd63, 16'h0000);
    in_g        = fp(0, 7'd62, 16'h0000);
    in_b        = fp(0, 7'd62, 16'h8000);
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    exp_addr    = 2;
    seen        = 0;
    last_pulses = 0;
    last_cycle  = 0;
    stray_last  = 0;
    for (int cyc = 0; cyc < (FRAME + 2) * 5 + 50 && seen < FRAME + 2; cyc++) begin
      tick();
      if (out_valid) begin
        check("stream_addr", out_addr, exp_addr);
        check("stream_last", out_last, (exp_addr == FRAME - 1) ? 1'b1 : 1'b0);
        check("stream_pixel", out_pixel, 16'hFC18);
        if (seen > 0) check("stream_gap", cyc - last_cycle, 5);
        if (out_last) last_pulses++;
        last_cycle = cyc;
        exp_addr   = (exp_addr + 1) % FRAME;
        seen++;
      end else if (out_last) begin
        stray_last++;
      end
    end
    in_valid = 1'b0;
    check("stream_count", seen, FRAME + 2);
    check("stream_last_pulses", last_pulses, 1);
    check("stream_last_without_valid", stray_last, 0);
    check("stream_wrapped_addr", out_addr, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
